// File: rtl/acc_sched_pkg.sv
// Shared constants for the accelerator scheduler: data width, defaults, FSM encoding.
package acc_sched_pkg;

    localparam int FE_DATA_W   = 32;
    localparam int ACC_NUM_REQ = 4;
    localparam int ACC_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } acc_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_sched_if.sv
// Requester, response and accelerator signals of the scheduler, bundled with modports.
interface acc_sched_if import acc_sched_pkg::*; #(
    parameter int NUM_REQ = ACC_NUM_REQ,
    parameter int DATA_W  = FE_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [NUM_REQ-1:0]        rsp_ready_i;
    logic [DATA_W-1:0]         rsp_data_o;
    logic                      rsp_err_o;
    logic                      acc_start_o;
    logic [DATA_W-1:0]         acc_data_o;
    logic [DATA_W-1:0]         acc_data_i;
    logic                      acc_done_i;
    logic                      busy_o;

    modport slave (
        input  req_valid_i, req_data_i, rsp_ready_i, acc_data_i, acc_done_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               acc_start_o, acc_data_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, rsp_ready_i, acc_data_i, acc_done_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               acc_start_o, acc_data_o, busy_o
    );
endinterface

// File: rtl/acc_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request above last_grant, wrapping.
module rr_arbiter import acc_sched_pkg::*; #(
    parameter  int NUM_REQ = ACC_NUM_REQ,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);
    always_comb begin
        int   k;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = int'(last_grant) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/acc_sched.sv
// Shares one accelerator among NUM_REQ requesters: round-robin accept, issue,
// wait for done (or time out), then hold the response until the winner takes it.
module acc_sched import acc_sched_pkg::*; #(
    parameter int NUM_REQ = ACC_NUM_REQ,
    parameter int DATA_W  = FE_DATA_W,
    parameter int TIMEOUT = ACC_TIMEOUT
) (
    input logic        clk_i,
    input logic        arst_n_i,
    acc_sched_if.slave bus
);
    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    acc_state_e        state, state_nxt;
    logic [IDX_W-1:0]  grant_idx, last_grant, arb_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic [DATA_W-1:0] operand, rsp_data;
    logic              rsp_err;
    logic [CNT_W-1:0]  cnt;
    logic              any_req, timed_out;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (bus.req_valid_i),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .idx        (arb_idx)
    );

    assign any_req = |bus.req_valid_i;
    // cnt holds the number of completed WAIT cycles, so this is the TIMEOUT-th one
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        bus.acc_start_o = 1'b0;
        case (state)
            ST_IDLE: begin
                // gated by reset so a pending request cannot leak an accept during reset
                if (arst_n_i) bus.req_ready_o = arb_grant;
                if (any_req) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.acc_start_o = 1'b1;
                state_nxt       = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.acc_done_i || timed_out) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid_o[grant_idx] = 1'b1;
                if (bus.rsp_ready_i[grant_idx]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            operand    <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: if (any_req) begin
                    grant_idx <= arb_idx;
                    operand   <= bus.req_data_i[int'(arb_idx)*DATA_W +: DATA_W];
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    // done beats a coincident timeout
                    if (bus.acc_done_i) begin
                        rsp_data <= bus.acc_data_i;
                        rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: if (bus.rsp_ready_i[grant_idx]) last_grant <= grant_idx;
                default: ;
            endcase
        end
    end

    assign bus.acc_data_o = operand;
    assign bus.rsp_data_o = rsp_data;
    assign bus.rsp_err_o  = rsp_err;
    assign bus.busy_o     = (state != ST_IDLE);
endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched; the accelerator model returns the byte sum of its operand.
module tb_acc_sched;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    int   lat = 0;
    int   wcnt;
    logic force_done = 1'b0;

    acc_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    acc_sched #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bsum(input logic [31:0] w);
        return 32'(w[7:0]) + 32'(w[15:8]) + 32'(w[23:16]) + 32'(w[31:24]);
    endfunction

    // wcnt = current WAIT cycle number since start; done fires in WAIT cycle 'lat' (0 = never)
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) wcnt <= 0;
        else if (bus.acc_start_o) wcnt <= 1;
        else if (wcnt != 0) begin
            if (wcnt == lat || wcnt >= 1000) wcnt <= 0;
            else wcnt <= wcnt + 1;
        end
    end
    assign bus.acc_done_i = force_done | (lat != 0 && wcnt == lat);
    assign bus.acc_data_i = bsum(bus.acc_data_o);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at an IDLE negedge; leaves the bench at the ISSUE negedge.
    task automatic accept(input int k, input logic [31:0] d);
        bus.req_valid_i[k]         = 1'b1;
        bus.req_data_i[k*DW +: DW] = d;
        #1;
        check("req_ready", 64'(bus.req_ready_o), 64'(1) << k);
        check("busy_idle", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
        bus.req_valid_i[k] = 1'b0;
    endtask

    // Called at the ISSUE negedge; waits for the response, optionally stalls, then handshakes.
    task automatic serve(input int k, input logic [31:0] opnd, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_cyc, input int stall);
        int n;
        check("acc_start", 64'(bus.acc_start_o), 64'd1);
        check("acc_data", 64'(bus.acc_data_o), 64'(opnd));
        check("busy_issue", 64'(bus.busy_o), 64'd1);
        @(negedge clk);
        n = 1;
        check("start_pulse", 64'(bus.acc_start_o), 64'd0);
        while (bus.rsp_valid_o == '0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(exp_cyc));
        check("rsp_valid", 64'(bus.rsp_valid_o), 64'(1) << k);
        check("rsp_data", 64'(bus.rsp_data_o), 64'(exp_data));
        check("rsp_err", 64'(bus.rsp_err_o), 64'(exp_err));
        for (int s = 0; s < stall; s++) begin
            bus.req_valid_i[(k+3)%NR] = 1'b1;
            bus.rsp_ready_i[(k+2)%NR] = 1'b1;
            @(negedge clk);
            check("stall_valid", 64'(bus.rsp_valid_o), 64'(1) << k);
            check("stall_data", 64'(bus.rsp_data_o), 64'(exp_data));
            check("stall_ready", 64'(bus.req_ready_o), 64'd0);
        end
        bus.req_valid_i = '0;
        bus.rsp_ready_i = '0;
        bus.rsp_ready_i[k] = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i[k] = 1'b0;
        check("rsp_drop", 64'(bus.rsp_valid_o), 64'd0);
        check("busy_done", 64'(bus.busy_o), 64'd0);
    endtask

    logic [31:0] rr_data [NR];
    logic [31:0] rr_exp  [NR];

    initial begin
        bus.req_valid_i = '1;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = '0;
        #12;
        check("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_start", 64'(bus.acc_start_o), 64'd0);
        check("rst_acc_data", 64'(bus.acc_data_o), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data_o), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err_o), 64'd0);
        bus.req_valid_i = '0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // all four requesting: grants 0,1,2,3
        rr_data[0] = 32'h01010101; rr_exp[0] = 32'd4;
        rr_data[1] = 32'h0a141e28; rr_exp[1] = 32'd100;
        rr_data[2] = 32'h00ff0001; rr_exp[2] = 32'd256;
        rr_data[3] = 32'hffffffff; rr_exp[3] = 32'd1020;
        lat = 2;
        for (int g = 0; g < NR; g++) bus.req_data_i[g*DW +: DW] = rr_data[g];
        bus.req_valid_i = '1;
        #1;
        for (int g = 0; g < NR; g++) begin
            check("rr_grant", 64'(bus.req_ready_o), 64'(1) << g);
            @(negedge clk);
            bus.req_valid_i[g] = 1'b0;
            serve(g, rr_data[g], rr_exp[g], 1'b0, 3, 0);
            bus.req_valid_i = '1;
            for (int j = 0; j <= g; j++) bus.req_valid_i[j] = 1'b0;
            #1;
        end
        bus.req_valid_i = '0;

        // single request, done after 3 cycles
        lat = 3;
        accept(0, 32'h04030201);
        serve(0, 32'h04030201, 32'd10, 1'b0, 4, 0);

        // backpressure: response held for 5 cycles
        lat = 2;
        accept(1, 32'h0a141e28);
        serve(1, 32'h0a141e28, 32'd100, 1'b0, 3, 5);

        // timeout, then a normal request
        lat = 0;
        accept(2, 32'h11223344);
        serve(2, 32'h11223344, 32'd0, 1'b1, TO + 1, 0);
        lat = 1;
        accept(3, 32'h01020304);
        serve(3, 32'h01020304, 32'd10, 1'b0, 2, 0);

        // done on the TIMEOUT-th wait cycle wins
        lat = TO;
        accept(0, 32'h10101010);
        serve(0, 32'h10101010, 32'd64, 1'b0, TO + 1, 0);

        // reset during WAIT drops the transaction
        lat = 4;
        accept(1, 32'h01010101);
        @(negedge clk);
        bus.req_valid_i[2] = 1'b1;
        arst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        check("mid_rst_acc_data", 64'(bus.acc_data_o), 64'd0);
        check("mid_rst_rsp_data", 64'(bus.rsp_data_o), 64'd0);
        check("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        bus.req_valid_i = '0;
        @(negedge clk);
        arst_n = 1'b1;
        force_done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) force_done = 1'b0;
            check("late_done_valid", 64'(bus.rsp_valid_o), 64'd0);
            check("late_done_busy", 64'(bus.busy_o), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/acc_sched.md
ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one accelerator.
REQ-002 Parameter DATA_W, default `FE_DATA_W (32), request/response word width.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before error abort.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 arst_n_i  in  1  asynchronous, active-low reset.
REQ-006 req_valid_i  in  NUM_REQ  request pending, one bit per requester.
REQ-007 req_data_i  in  NUM_REQ*DATA_W  request words; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 req_ready_o  out  NUM_REQ  one-hot accept strobe.
REQ-009 rsp_valid_o  out  NUM_REQ  one-hot response valid to granted requester.
REQ-010 rsp_ready_i  in  NUM_REQ  response accepted, one bit per requester.
REQ-011 rsp_data_o  out  DATA_W  shared response word.
REQ-012 rsp_err_o  out  1  response is timeout error; qualified by rsp_valid_o.
REQ-013 acc_start_o  out  1  accelerator start pulse.
REQ-014 acc_data_o  out  DATA_W  accelerator operand word.
REQ-015 acc_data_i  in  DATA_W  accelerator result.
REQ-016 acc_done_i  in  1  accelerator completion.
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_valid_i bit set, grant g = first set bit searching upward (with wrap) from last_grant+1; assert req_ready_o[g] combinationally that cycle; capture req_data_i slice g into operand register; go ISSUE.
REQ-020 IDLE with no request: stay IDLE, req_ready_o = 0.
REQ-021 ISSUE: acc_start_o = 1 for exactly one cycle; clear timeout counter; go WAIT.
REQ-022 acc_data_o SHALL equal the operand register from ISSUE through end of WAIT, stable.
REQ-023 WAIT: on acc_done_i = 1, capture acc_data_i into rsp_data_o register, rsp_err_o = 0, go RESP.
REQ-024 WAIT: counter increments each cycle without done; when counter reaches TIMEOUT with no done, rsp_data_o = 0, rsp_err_o = 1, go RESP.
REQ-025 Done and timeout in the same cycle: done wins (no error).
REQ-026 acc_done_i outside WAIT SHALL be ignored.
REQ-027 RESP: rsp_valid_o[g] = 1, held with stable rsp_data_o/rsp_err_o until rsp_ready_i[g] = 1; on that edge last_grant <= g, go IDLE.
REQ-028 rsp_ready_i bits other than g SHALL be ignored; req_valid_i ignored outside IDLE.
REQ-029 Latency: accept to acc_start_o = 1 cycle; done to rsp_valid_o = 1 cycle; minimum accept-to-accept = 4 cycles.
REQ-030 Fairness: a continuously requesting requester SHALL be granted within NUM_REQ grants.

Reset
REQ-031 On arst_n_i low, immediately and regardless of state: state = IDLE, all outputs 0, counter 0, operand/result registers 0, last_grant = NUM_REQ-1 (requester 0 highest priority first).
REQ-032 Reset mid-transaction SHALL drop the transaction with no response; accelerator done arriving after release SHALL be ignored.

Structure
REQ-033 State encoding and default NUM_REQ/TIMEOUT values SHALL live in the shared constants header alongside `FE_DATA_W.
REQ-034 Round-robin selection SHALL be a separate combinational sub-module rr_arbiter (inputs request vector, last_grant; outputs one-hot grant, index).

Verification
REQ-035 Single request: req_valid_i[0], data {4,3,2,1}; accelerator model returns 10 after 3 cycles -> one acc_start_o pulse, rsp_valid_o[0] with rsp_data_o = 10, rsp_err_o = 0.
REQ-036 All four requesters valid after reset -> grants in order 0,1,2,3, each response matches its own operand sum (e.g. 1020 for {255,255,255,255}).
REQ-037 Timeout: model never asserts done -> rsp_valid_o after TIMEOUT WAIT cycles, rsp_data_o = 0, rsp_err_o = 1; next request served normally.
REQ-038 Backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o and rsp_data_o stable, no new req_ready_o until handshake.
REQ-039 Reset asserted during WAIT -> all outputs 0 at once; late acc_done_i after release produces no response.
REQ-040 Done and timeout same cycle (done on cycle TIMEOUT) -> rsp_err_o = 0, result captured.
